uart_spi_word_bridge: RTL
=========================

Name: uart_spi_word_bridge

Overview:
Controller between the UART byte interface and the SPI master/slave core. It packs two received UART bytes (MSB first) into a 16-bit word and launches one SPI transfer. It waits for that transfer to complete, then returns the 16-bit SPI receive word over UART as two bytes (MSB first). It sits directly upstream of the SPI core and drives that core's start inputs and transmit word.

Parameters:
BYTE_TIMEOUT, 50000, max clk cycles allowed between the first and second byte of a frame
SPI_TIMEOUT, 4096, max clk cycles allowed from spi_start until both SPI completion flags are seen

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset; 0 = reset asserted
uart_rx_data  input  8  received byte; valid only while uart_rx_valid=1
uart_rx_valid  input  1  one-cycle strobe per received byte
uart_tx_data  output  8  byte to transmit; held stable from the uart_tx_start pulse until uart_tx_busy falls
uart_tx_start  output  1  one-cycle transmit request
uart_tx_busy  input  1  UART transmitter busy; rises the cycle after uart_tx_start, stays high until the byte is sent
spi_tx_word  output  16  word for the SPI core; held stable from spi_start until return to IDLE
spi_start  output  1  one-cycle pulse; drives the SPI core's slave_rx_start and slave_tx_start together
spi_tx_done  input  1  SPI core transmit-complete flag
spi_rx_valid  input  1  SPI core receive-complete flag
spi_rx_word  input  16  SPI core receive word; sampled in the cycle both completion flags have been seen
busy  output  1  high in every state except IDLE
frame_err  output  1  one-cycle pulse on inter-byte timeout
spi_err  output  1  one-cycle pulse on SPI timeout
overrun  output  1  one-cycle pulse when a byte arrives while busy and not in WAIT_LO

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0. spi_tx_word=0, uart_tx_data=0. Counters, sticky flags and the reply register cleared. Reset mid-operation aborts the frame; no partial byte is retained.
- All outputs are registered. State changes on clk rising edge.
- IDLE: on uart_rx_valid, store the byte in spi_tx_word[15:8], clear the timeout counter, go to WAIT_LO.
- WAIT_LO:
  - on uart_rx_valid: spi_tx_word[7:0]=byte; spi_start=1 on the next cycle; go to SPI_WAIT.
  - otherwise the counter increments; when it reaches BYTE_TIMEOUT: frame_err pulse, go to IDLE, no SPI transfer.
  - A byte arriving in the same cycle the counter reaches BYTE_TIMEOUT is accepted; the timeout does not fire.
- SPI_WAIT:
  - Latency: spi_start asserts exactly 1 cycle after the second byte's uart_rx_valid.
  - spi_tx_done and spi_rx_valid are each latched into a sticky flag; they may arrive in any order or in the same cycle.
  - When both flags are set (including via the current-cycle inputs): capture spi_rx_word into the reply register, go to TX_HI.
  - Counter starts at spi_start; at SPI_TIMEOUT: spi_err pulse, go to IDLE, no reply sent.
  - Completion in the same cycle as the timeout wins.
- TX_HI: when uart_tx_busy=0, uart_tx_data=reply[15:8], uart_tx_start pulse, go to TX_HI_WAIT.
- TX_HI_WAIT: ignore busy in the first cycle (guard); then wait for uart_tx_busy=0, go to TX_LO.
- TX_LO / TX_LO_WAIT: same handshake with reply[7:0]; on completion go to IDLE.
- Bytes with uart_rx_valid in SPI_WAIT or any TX state are dropped and pulse overrun; state is unaffected.
- spi_start and uart_tx_start are never high in consecutive cycles, and never high outside their own states.
- Sticky flags clear on entry to SPI_WAIT.

Test Plan:
1. Bytes 0x55, 0xAA; SPI model returns tx_done+rx_valid together with spi_rx_word=0x55AA -> spi_tx_word=0x55AA, single spi_start one cycle after second byte; UART emits 0x55 then 0xAA; busy falls after second byte completes.
2. Bytes 0xA5, 0x5A; rx_valid 3 cycles before tx_done, spi_rx_word=0x1234 -> reply captured only when both seen; UART emits 0x12 then 0x34.
3. Single byte 0x12, no second byte for BYTE_TIMEOUT cycles -> frame_err one pulse, no spi_start, busy=0; following 0x34,0x56 frame works normally (spi_tx_word=0x3456).
4. Full frame, SPI model never completes -> spi_err pulse exactly SPI_TIMEOUT cycles after spi_start, no uart_tx_start, return to IDLE.
5. Extra byte 0xFF injected during SPI_WAIT and during TX_HI_WAIT -> overrun pulses twice; reply bytes unchanged; spi_tx_word unchanged.
6. Assert reset during TX_LO_WAIT and during WAIT_LO -> all outputs 0 immediately (async); after release, frame 0xBE,0xEF -> spi_tx_word=0xBEEF with no stale high byte.

Source files
------------

// File: rtl/uart_spi_word_bridge.sv
// Packs two UART bytes into one SPI word transfer and returns the SPI reply as two UART bytes, MSB first.
// spi_start 1 cycle after the second byte; UART sends stall on uart_tx_busy; bytes arriving mid-transfer are dropped with overrun.
module uart_spi_word_bridge #(
    parameter int BYTE_TIMEOUT = 50000,
    parameter int SPI_TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_start,
    input  logic        uart_tx_busy,
    output logic [15:0] spi_tx_word,
    output logic        spi_start,
    input  logic        spi_tx_done,
    input  logic        spi_rx_valid,
    input  logic [15:0] spi_rx_word,
    output logic        busy,
    output logic        frame_err,
    output logic        spi_err,
    output logic        overrun
);

    localparam int MAX_TO = (BYTE_TIMEOUT > SPI_TIMEOUT) ? BYTE_TIMEOUT : SPI_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_TO + 1);
    localparam logic [CNT_W-1:0] BYTE_LIM = CNT_W'(BYTE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SPI_LIM  = CNT_W'(SPI_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_LO    = 3'd1;
    localparam logic [2:0] S_SPI_WAIT   = 3'd2;
    localparam logic [2:0] S_TX_HI      = 3'd3;
    localparam logic [2:0] S_TX_HI_WAIT = 3'd4;
    localparam logic [2:0] S_TX_LO      = 3'd5;
    localparam logic [2:0] S_TX_LO_WAIT = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_seen_q, done_seen_d;
    logic             rx_seen_q, rx_seen_d;
    logic [15:0]      reply_q, reply_d;
    logic             guard_q, guard_d;
    logic [15:0]      spi_tx_word_q, spi_tx_word_d;
    logic             spi_start_q, spi_start_d;
    logic [7:0]       uart_tx_data_q, uart_tx_data_d;
    logic             uart_tx_start_q, uart_tx_start_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             spi_err_q, spi_err_d;
    logic             overrun_q, overrun_d;
    logic             done_now, rx_now;

    assign done_now = done_seen_q | spi_tx_done;
    assign rx_now   = rx_seen_q | spi_rx_valid;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        done_seen_d     = done_seen_q;
        rx_seen_d       = rx_seen_q;
        reply_d         = reply_q;
        guard_d         = guard_q;
        spi_tx_word_d   = spi_tx_word_q;
        uart_tx_data_d  = uart_tx_data_q;
        spi_start_d     = 1'b0;
        uart_tx_start_d = 1'b0;
        frame_err_d     = 1'b0;
        spi_err_d       = 1'b0;
        overrun_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (uart_rx_valid) begin
                    spi_tx_word_d = {uart_rx_data, 8'h00};
                    cnt_d         = '0;
                    state_d       = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                // A byte on the last allowed cycle beats the timeout.
                if (uart_rx_valid) begin
                    spi_tx_word_d[7:0] = uart_rx_data;
                    spi_start_d        = 1'b1;
                    cnt_d              = '0;
                    done_seen_d        = 1'b0;
                    rx_seen_d          = 1'b0;
                    state_d            = S_SPI_WAIT;
                end else if (cnt_q == BYTE_LIM) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SPI_WAIT: begin
                overrun_d   = uart_rx_valid;
                done_seen_d = done_now;
                rx_seen_d   = rx_now;
                if (done_now && rx_now) begin
                    reply_d = spi_rx_word;
                    state_d = S_TX_HI;
                end else if (cnt_q == SPI_LIM) begin
                    spi_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_TX_HI: begin
                overrun_d = uart_rx_valid;
                if (!uart_tx_busy) begin
                    uart_tx_data_d  = reply_q[15:8];
                    uart_tx_start_d = 1'b1;
                    guard_d         = 1'b1;
                    state_d         = S_TX_HI_WAIT;
                end
            end
            S_TX_HI_WAIT: begin
                // busy only rises the cycle after start, so the first cycle is skipped.
                overrun_d = uart_rx_valid;
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!uart_tx_busy) begin
                    state_d = S_TX_LO;
                end
            end
            S_TX_LO: begin
                overrun_d = uart_rx_valid;
                if (!uart_tx_busy) begin
                    uart_tx_data_d  = reply_q[7:0];
                    uart_tx_start_d = 1'b1;
                    guard_d         = 1'b1;
                    state_d         = S_TX_LO_WAIT;
                end
            end
            S_TX_LO_WAIT: begin
                overrun_d = uart_rx_valid;
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!uart_tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            done_seen_q     <= 1'b0;
            rx_seen_q       <= 1'b0;
            reply_q         <= '0;
            guard_q         <= 1'b0;
            spi_tx_word_q   <= '0;
            spi_start_q     <= 1'b0;
            uart_tx_data_q  <= '0;
            uart_tx_start_q <= 1'b0;
            busy_q          <= 1'b0;
            frame_err_q     <= 1'b0;
            spi_err_q       <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            done_seen_q     <= done_seen_d;
            rx_seen_q       <= rx_seen_d;
            reply_q         <= reply_d;
            guard_q         <= guard_d;
            spi_tx_word_q   <= spi_tx_word_d;
            spi_start_q     <= spi_start_d;
            uart_tx_data_q  <= uart_tx_data_d;
            uart_tx_start_q <= uart_tx_start_d;
            busy_q          <= busy_d;
            frame_err_q     <= frame_err_d;
            spi_err_q       <= spi_err_d;
            overrun_q       <= overrun_d;
        end
    end

    assign uart_tx_data  = uart_tx_data_q;
    assign uart_tx_start = uart_tx_start_q;
    assign spi_tx_word   = spi_tx_word_q;
    assign spi_start     = spi_start_q;
    assign busy          = busy_q;
    assign frame_err     = frame_err_q;
    assign spi_err       = spi_err_q;
    assign overrun       = overrun_q;

endmodule
